// File: rtl/m_seq_sync_detector.sv
// Sliding-window M-sequence correlator: builds the reference code, acquires the
// period boundary, then tracks it once per period until repeated misses drop lock.
module m_seq_sync_detector #(
    parameter int unsigned       N        = 63,
    parameter int unsigned       LENGTH   = $clog2(N),
    parameter int unsigned       CW       = $clog2(N + 1),
    parameter logic [LENGTH-1:0] POLYNOME = 6'b100111,
    parameter logic [LENGTH-1:0] SEED     = 6'b101010,
    parameter int unsigned       THRESH   = 60,
    parameter int unsigned       MISS_MAX = 3
) (
    input  logic          clkin,
    input  logic          rstn,
    input  logic          chip_i,
    input  logic          chip_valid_i,
    output logic          ready_o,
    output logic          sync_o,
    output logic          detect_o,
    output logic [CW-1:0] corr_o,
    output logic [1:0]    miss_o
);

    typedef enum logic [1:0] {
        S_INIT,
        S_SEARCH,
        S_LOCKED
    } state_t;

    state_t            state;
    logic [LENGTH-1:0] lfsr;
    logic [LENGTH-1:0] init_cnt;
    logic [LENGTH-1:0] chip_cnt;
    logic [N-1:0]      ref_code;
    logic [N-1:0]      window;
    logic [CW-1:0]     fill;

    logic [N-1:0]      win_next;
    logic [N-1:0]      diff;
    logic [CW-1:0]     mism;
    logic [CW-1:0]     agree;
    logic              match;
    logic              accept;

    // Score is taken on the window as it will look after the current chip
    always_comb begin
        win_next = {window[N-2:0], chip_i};
        diff     = win_next ^ ref_code;
        mism     = '0;
        for (int i = 0; i < int'(N); i++) begin
            mism = mism + CW'(diff[i]);
        end
        agree  = CW'(N) - mism;
        match  = (agree >= CW'(THRESH));
        accept = chip_valid_i && (state != S_INIT);
    end

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            state    <= S_INIT;
            lfsr     <= SEED;
            init_cnt <= '0;
            chip_cnt <= '0;
            ref_code <= '0;
            window   <= '0;
            fill     <= '0;
            ready_o  <= 1'b0;
            sync_o   <= 1'b0;
            detect_o <= 1'b0;
            corr_o   <= '0;
            miss_o   <= '0;
        end else begin
            detect_o <= 1'b0;

            if (accept) begin
                window <= win_next;
                if (fill != CW'(N)) begin
                    fill <= fill + CW'(1);
                end
            end

            case (state)
                S_INIT: begin
                    ref_code <= {ref_code[N-2:0], lfsr[0]};
                    lfsr     <= {^(POLYNOME & lfsr), lfsr[LENGTH-1:1]};
                    if (init_cnt == LENGTH'(N - 1)) begin
                        ready_o <= 1'b1;
                        state   <= S_SEARCH;
                    end else begin
                        init_cnt <= init_cnt + LENGTH'(1);
                    end
                end

                S_SEARCH: begin
                    // fill reaches N with this chip
                    if (accept && (fill >= CW'(N - 1))) begin
                        corr_o <= agree;
                        if (match) begin
                            detect_o <= 1'b1;
                            sync_o   <= 1'b1;
                            chip_cnt <= '0;
                            miss_o   <= '0;
                            state    <= S_LOCKED;
                        end
                    end
                end

                S_LOCKED: begin
                    if (accept) begin
                        if (chip_cnt == LENGTH'(N - 1)) begin
                            chip_cnt <= '0;
                            corr_o   <= agree;
                            detect_o <= 1'b1;
                            if (match) begin
                                miss_o <= '0;
                            end else if (miss_o == 2'(MISS_MAX - 1)) begin
                                // window is kept so the very next chip may relock
                                miss_o <= '0;
                                sync_o <= 1'b0;
                                state  <= S_SEARCH;
                            end else begin
                                miss_o <= miss_o + 2'd1;
                            end
                        end else begin
                            chip_cnt <= chip_cnt + LENGTH'(1);
                        end
                    end
                end

                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: doc/m_seq_sync_detector.md
Name: m_seq_sync_detector

Overview:
- Receive-side stage downstream of the M-sequence generator. Consumes the serial chip stream one chip per chip_valid_i and finds the code boundary with a sliding N-chip correlator.
- Declares sync, then tracks it once per period and drops lock after repeated misses.
- Feeds the despreader/phase-recovery logic with a per-period boundary strobe and a correlation score.

Parameters:
- POLYNOME, 6'b100111: feedback taps without the leading 1; must match the transmitter.
- SEED, 6'b101010: LFSR start state of the reference period; must be nonzero.
- N, 63: code length in chips.
- LENGTH, $clog2(N): LFSR width.
- CW, $clog2(N+1): width of the correlation score.
- THRESH, 60: minimum agreeing chips that count as a match.
- MISS_MAX, 3: consecutive missed periods that drop lock.

Ports:
- clkin  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- chip_i  in  1  received chip, sampled when chip_valid_i=1
- chip_valid_i  in  1  one-cycle strobe per chip
- ready_o  out  1  1 once the reference is built; chips are ignored while 0
- sync_o  out  1  1 while in LOCKED
- detect_o  out  1  one-cycle pulse at each accepted period boundary
- corr_o  out  CW  agreement count of the latest evaluation
- miss_o  out  2  current consecutive-miss count

Behaviour:
- Reset: one clock (clkin); reset is asynchronous and active-low on rstn.
  - Reset values: ready_o=0, sync_o=0, detect_o=0, corr_o=0, miss_o=0.
  - window, ref, chip counter and miss count are cleared.
  - State goes to INIT.
  - Reset asserted mid-operation aborts everything; INIT reruns after release.
- INIT state (N cycles, one per clock, independent of chip_valid_i):
  - Reference LFSR is loaded with SEED.
  - Each cycle: ref <= {ref[N-2:0], lfsr[0]}, then lfsr <= {^(POLYNOME & lfsr), lfsr[LENGTH-1:1]}.
  - Result: ref[N-1] holds the first chip and ref[0] the last.
  - After N cycles: ready_o <= 1, state goes to SEARCH.
  - chip_valid_i is ignored in INIT.
- Window: on each accepted chip, window <= {window[N-2:0], chip_i}; the newest chip is at bit 0.
  - fill counter saturates at N.
  - No evaluation happens until fill == N.
- Score: agree = N - popcount(window ^ ref), computed on the updated window.
  - Registered into corr_o one clkin after the chip_valid_i cycle (latency 1).
  - detect_o is asserted in that same cycle.
- SEARCH state: evaluate on every accepted chip once filled.
  - If agree >= THRESH: detect_o pulse, state goes to LOCKED, chip counter = 0, miss = 0.
  - Otherwise corr_o is still updated, with no pulse.
- LOCKED state: sync_o=1. The chip counter counts accepted chips modulo N; evaluation happens only when it wraps N-1 -> 0.
  - If agree >= THRESH: detect_o pulse, miss = 0.
  - If agree < THRESH: detect_o pulse still fires (free-wheel boundary) and miss increments.
  - If miss reaches MISS_MAX: sync_o <= 0 and state goes to SEARCH with miss = 0. The window is kept, so a match on the next chip is allowed.
- Simultaneous events: a match and the lock transition happen in the same evaluation.
- Input rules:
  - chip_valid_i with no gap on consecutive clocks must be supported.
  - Gaps of any length have no effect: the window and counters only move on valid chips.
- corr_o holds its last value between evaluations.

Test Plan:
- Reset release -> ready_o=0 for exactly 63 clocks, then 1. ref equals the 63 chips of LFSR(100111) seeded 101010. Chips sent during INIT do not change the window.
- Reset, then send 63 random chips, then one full clean period:
  - detect_o pulses one clkin after the 63rd chip of the period.
  - corr_o=63, sync_o=1.
  - No detect_o pulse earlier.
- Continuous clean periods with chip_valid_i every 3rd clock (HOLD=3 style):
  - detect_o pulses every 63 chips, i.e. every 189 clocks.
  - corr_o=63 each time, miss_o=0.
- Locked stream with 3 chips flipped in one period -> corr_o=60, still a match, miss_o stays 0.
- Locked stream with 4 flips in one period -> corr_o=59, miss_o=1, sync_o still 1.
- Locked stream with 3 consecutive corrupted periods -> miss_o goes 1, 2, then sync_o=0 and state is SEARCH. A clean period afterwards relocks with corr_o=63.
- Assert rstn low mid-period while LOCKED -> all outputs go to 0 immediately, asynchronously. INIT reruns on release.
